// File: rtl/mem_arbiter.sv
// Purpose : arbitrates one shared pipelined memory port between an I-cache
//           (block fills) and a D-cache (block fills and single-word writes).
// Latency : grant one cycle after a request is seen in IDLE; fills issue one
//           read per cycle; a write completes in its single WRITE cycle.
// Backpressure: none on the memory side; requesters hold req until done, and
//           a waiting requester simply stays pending while the other owns the port.
// Ports   : clk/rst            clock, async active-high reset
//           i_req/i_addr       I-side fill request and byte address
//           d_req/d_wr/d_addr/d_wdata  D-side request (write or fill)
//           mem_en/mem_wr/mem_addr/mem_wdata  issued memory access
//           mem_rdata/mem_rvalid  in-order read return
//           fill_data/fill_word/i_fill_we/d_fill_we  fill path into caches
//           i_done/d_done      one-cycle completion pulses; busy = not IDLE
module mem_arbiter #(
  parameter int BLOCK_WORDS = 8,
  localparam int WW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [15:0]   i_addr,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [15:0]   d_addr,
  input  logic [15:0]   d_wdata,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [15:0]   mem_addr,
  output logic [15:0]   mem_wdata,
  input  logic [15:0]   mem_rdata,
  input  logic          mem_rvalid,
  output logic [15:0]   fill_data,
  output logic [WW-1:0] fill_word,
  output logic          i_fill_we,
  output logic          d_fill_we,
  output logic          i_done,
  output logic          d_done,
  output logic          busy
);

  // Clears the byte-within-line bits to get the block base address.
  localparam logic [15:0] BASE_MASK = ~16'((2 * BLOCK_WORDS) - 1);
  localparam logic [WW:0]   ISSUE_END = (WW + 1)'(BLOCK_WORDS);
  localparam logic [WW-1:0] LAST_WORD = WW'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL_I = 2'd1,
    FILL_D = 2'd2,
    WRITE  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [15:0]   lat_addr;
  logic [15:0]   lat_wdata;
  logic [WW:0]   issue_cnt;   // one extra bit so "all issued" is representable
  logic [WW-1:0] recv_cnt;

  logic filling;
  logic issuing;
  logic last_rx;

  assign filling = (state == FILL_I) || (state == FILL_D);
  assign issuing = filling && (issue_cnt != ISSUE_END);
  assign last_rx = filling && mem_rvalid && (recv_cnt == LAST_WORD);

  // Next-state: D side wins ties; an owner runs to completion.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (d_req)      state_nxt = d_wr ? WRITE : FILL_D;
        else if (i_req) state_nxt = FILL_I;
      end
      FILL_I, FILL_D: if (last_rx) state_nxt = IDLE;
      WRITE:          state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_wdata <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else begin
      state <= state_nxt;
      // Owner's address/data captured only on the grant edge, so requesters
      // may change their inputs freely afterwards.
      if (state == IDLE && state_nxt != IDLE) begin
        case (state_nxt)
          FILL_I:  lat_addr <= i_addr & BASE_MASK;
          FILL_D:  lat_addr <= d_addr & BASE_MASK;
          default: lat_addr <= d_addr;
        endcase
        lat_wdata <= (state_nxt == WRITE) ? d_wdata : 16'h0000;
      end
      if (state_nxt == IDLE) begin
        issue_cnt <= '0;
        recv_cnt  <= '0;
      end else begin
        if (issuing)                 issue_cnt <= issue_cnt + 1'b1;
        if (filling && mem_rvalid)   recv_cnt  <= recv_cnt + 1'b1;
      end
    end
  end

  // Outputs are purely combinational from state, so an asynchronous reset
  // drops them in the same instant the state register clears.
  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    fill_data = 16'h0000;
    fill_word = '0;
    i_fill_we = 1'b0;
    d_fill_we = 1'b0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    busy      = (state != IDLE);

    if (issuing) begin
      mem_en   = 1'b1;
      // Base is block-aligned and the offset stays inside the block, so this
      // add never carries out of the line.
      mem_addr = lat_addr + (16'(issue_cnt) << 1);
    end

    if (filling && mem_rvalid) begin
      fill_data = mem_rdata;
      fill_word = recv_cnt;
      i_fill_we = (state == FILL_I);
      d_fill_we = (state == FILL_D);
    end

    if (last_rx) begin
      i_done = (state == FILL_I);
      d_done = (state == FILL_D);
    end

    if (state == WRITE) begin
      mem_en    = 1'b1;
      mem_wr    = 1'b1;
      mem_addr  = lat_addr;
      mem_wdata = lat_wdata;
      d_done    = 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = 16'h0;
  logic        d_req = 1'b0;
  logic        d_wr = 1'b0;
  logic [15:0] d_addr = 16'h0;
  logic [15:0] d_wdata = 16'h0;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 16'h0;
  logic        mem_rvalid = 1'b0;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        i_fill_we, d_fill_we, i_done, d_done, busy;

  mem_arbiter #(.BLOCK_WORDS(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .fill_data(fill_data), .fill_word(fill_word),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_done(i_done), .d_done(d_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fills_seen = 0;
  bit done_prev = 1'b0;

  // Scoreboard queues: {wr, addr, wdata}; {d_we, i_we, word, data}; {last_fill, d_done, i_done}
  logic [32:0] acc_q[$];
  logic [20:0] fill_q[$];
  logic [2:0]  done_q[$];
  // Memory model pending reads
  int          pend_due[$];
  logic [15:0] pend_addr[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  task automatic push_fill(input bit is_d, input logic [15:0] addr, input int n_acc,
                           input int n_fill, input bit with_done);
    logic [15:0] base;
    logic [15:0] a;
    base = addr & 16'hFFF0;
    for (int k = 0; k < n_acc; k++) begin
      a = base + 16'(2 * k);
      acc_q.push_back({1'b0, a, 16'h0000});
    end
    for (int k = 0; k < n_fill; k++) begin
      a = base + 16'(2 * k);
      fill_q.push_back({is_d, !is_d, 3'(k), mem_val(a)});
    end
    if (with_done) done_q.push_back({1'b1, is_d, !is_d});
  endtask

  task automatic push_write(input logic [15:0] a, input logic [15:0] w);
    acc_q.push_back({1'b1, a, w});
    done_q.push_back(3'b010);
  endtask

  task automatic wait_done(input bit is_d);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      seen = is_d ? d_done : i_done;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout: side d=%0d got no done want done within 300 cycles", is_d);
    end
  endtask

  task automatic req_i(input logic [15:0] a, input bit scramble);
    @(posedge clk); #1;
    i_addr = a;
    i_req  = 1'b1;
    if (scramble) begin
      @(posedge clk); #1;
      i_addr = ~a;
    end
    wait_done(1'b0);
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  task automatic req_d(input bit wr, input logic [15:0] a, input logic [15:0] w, input bit scramble);
    @(posedge clk); #1;
    d_addr  = a;
    d_wdata = w;
    d_wr    = wr;
    d_req   = 1'b1;
    if (scramble) begin
      @(posedge clk); #1;
      d_addr  = ~a;
      d_wdata = ~w;
    end
    if (!(scramble && wr)) wait_done(1'b1);
    else begin
      // Write completes in the cycle just entered; confirm at its negedge.
      @(negedge clk);
      if (!d_done) wait_done(1'b1);
    end
    @(posedge clk); #1;
    d_req = 1'b0;
    d_wr  = 1'b0;
  endtask

  // Memory model: drive read returns LAT cycles after issue, in order.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_val(pend_addr[0]);
      void'(pend_due.pop_front());
      void'(pend_addr.pop_front());
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 16'($urandom);
    end
  end

  // Monitor: compares whatever the DUT presents against the queues.
  always @(negedge clk) begin
    if (rst) begin
      done_prev = 1'b0;
    end else begin
      if (done_prev) chk("turnaround_idle", 64'(busy), 64'd0);
      done_prev = i_done | d_done;
      if (mem_en) begin
        if (acc_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_access: got wr=%0d addr=%h want no access", mem_wr, mem_addr);
        end else begin
          chk("mem_access", 64'({mem_wr, mem_addr, mem_wdata}), 64'(acc_q.pop_front()));
        end
        if (!mem_wr) begin
          pend_due.push_back(cyc + LAT);
          pend_addr.push_back(mem_addr);
        end
      end
      if (i_fill_we | d_fill_we) begin
        fills_seen++;
        if (fill_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_fill: got word=%0d data=%h want no fill_we", fill_word, fill_data);
        end else begin
          chk("fill", 64'({d_fill_we, i_fill_we, fill_word, fill_data}), 64'(fill_q.pop_front()));
        end
      end
      if (i_done | d_done) begin
        if (done_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got d=%0d i=%0d want none", d_done, i_done);
        end else begin
          chk("done", 64'({(i_fill_we | d_fill_we) && fill_word == 3'd7, d_done, i_done}),
              64'(done_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation got no finish want finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int tgt;
    // Reset state
    #23;
    chk("reset_outputs",
        64'({mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
             i_fill_we, d_fill_we, i_done, d_done, busy}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 64'({busy, mem_en}), 64'd0);

    // Basic I fill, unaligned address, address changed after grant
    push_fill(1'b0, 16'h0046, 8, 8, 1'b1);
    req_i(16'h0046, 1'b1);
    repeat (8) @(posedge clk);

    // Simultaneous I and D fill: D first, then I
    push_fill(1'b1, 16'h1230, 8, 8, 1'b1);
    push_fill(1'b0, 16'h0880, 8, 8, 1'b1);
    fork
      req_d(1'b0, 16'h1230, 16'h0000, 1'b0);
      req_i(16'h0880, 1'b0);
    join
    repeat (8) @(posedge clk);

    // D write arriving during an I fill waits for i_done
    push_fill(1'b0, 16'h0300, 8, 8, 1'b1);
    push_write(16'h4444, 16'h1234);
    fork
      req_i(16'h0300, 1'b0);
      begin
        repeat (3) @(posedge clk);
        req_d(1'b1, 16'h4444, 16'h1234, 1'b0);
      end
    join
    repeat (8) @(posedge clk);

    // Single write, data changed after grant
    push_write(16'h2002, 16'hBEEF);
    req_d(1'b1, 16'h2002, 16'hBEEF, 1'b1);
    repeat (8) @(posedge clk);

    // Top-of-memory block: no wrap to 0x0000
    push_fill(1'b0, 16'hFFFA, 8, 8, 1'b1);
    req_i(16'hFFFA, 1'b0);
    repeat (8) @(posedge clk);

    // Reset after the third return of a fill: 7 reads issued, 3 fills, no done
    push_fill(1'b0, 16'h0500, 7, 3, 1'b0);
    tgt = fills_seen + 3;
    @(posedge clk); #1;
    i_addr = 16'h0500;
    i_req  = 1'b1;
    for (int n = 0; n < 100 && fills_seen < tgt; n++) begin
      @(negedge clk); #1;
    end
    rst   = 1'b1;
    i_req = 1'b0;
    #1;
    chk("rst_mid_fill_outputs",
        64'({mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
             i_fill_we, d_fill_we, i_done, d_done, busy}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);

    // Port usable again after the aborted fill
    push_write(16'h0ABC, 16'h5555);
    req_d(1'b1, 16'h0ABC, 16'h5555, 1'b0);
    repeat (12) @(posedge clk);

    chk("acc_q_empty",  64'(acc_q.size()),  64'd0);
    chk("fill_q_empty", 64'(fill_q.size()), 64'd0);
    chk("done_q_empty", 64'(done_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
